// File: rtl/mips_pkg.sv
// Shared MIPS write-back definitions: load types, result selects and the late-write queue entry.
package mips_pkg;

    localparam int GPR_ADDR_W = 5;
    localparam int GPR_DATA_W = 32;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    typedef struct packed {
        logic [GPR_ADDR_W-1:0] rd;
        logic [GPR_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_late_fifo.sv
// Circular buffer holding multi-cycle completions until the GPR write port is free.
module wb_late_fifo
    import mips_pkg::*;
#(
    parameter int LQ_DEPTH = 2,
    parameter int CNT_W    = $clog2(LQ_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  wb_entry_t        entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

    wb_entry_t        mem_q [LQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_next(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/gpr_writeback_unit.sv
// GPR write-port master: arbitrates MEM/WB results against queued late completions,
// aligns load data, tracks outstanding late writes and drives the same-cycle forward path.
module gpr_writeback_unit
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [1:0]        mem_sel,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic [DATA_W-1:0] mem_ldata,
    input  logic [2:0]        mem_ltype,
    input  logic [1:0]        mem_boff,
    input  logic [DATA_W-1:0] mem_link,
    input  logic              late_issue,
    input  logic [ADDR_W-1:0] late_issue_rd,
    input  logic              late_valid,
    output logic              late_ready,
    input  logic [ADDR_W-1:0] late_rd,
    input  logic [DATA_W-1:0] late_data,
    output logic              wGPR,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] rs_q,
    input  logic [ADDR_W-1:0] rt_q,
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       pend_mask,
    output logic              sb_err
);

    localparam int CNT_W = $clog2(LQ_DEPTH + 1);

    logic [CNT_W-1:0]  lq_count;
    wb_entry_t         lq_head, lq_in;
    logic              lq_full, lq_push, lq_pop, mem_fire;
    logic [DATA_W-1:0] mem_result;

    logic              wgpr_q, wgpr_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [31:0]       pend_q, pend_d;
    logic              err_q, err_d;

    function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] w,
                                                     input logic [2:0]        lt,
                                                     input logic [1:0]        boff);
        logic signed [7:0]        b;
        logic signed [15:0]       h;
        logic signed [DATA_W-1:0] r;
        b = w[8*boff +: 8];
        h = w[16*boff[1] +: 16];
        case (lt)
            LT_LB:   r = b;
            LT_LBU:  r = {{(DATA_W-8){1'b0}}, b};
            LT_LH:   r = h;
            LT_LHU:  r = {{(DATA_W-16){1'b0}}, h};
            LT_LW:   r = w;
            default: r = w;
        endcase
        return r;
    endfunction

    // Readiness looks only at the registered count, so a full queue forces one drain cycle.
    assign lq_full    = (lq_count == CNT_W'(LQ_DEPTH));
    assign mem_ready  = !lq_full;
    assign late_ready = !lq_full;
    assign mem_fire   = mem_valid && mem_ready;
    assign lq_push    = late_valid && late_ready;
    assign lq_pop     = !mem_fire && (lq_count != '0);

    always_comb begin
        lq_in      = '0;
        lq_in.rd   = late_rd;
        lq_in.data = late_data;
    end

    wb_late_fifo #(
        .LQ_DEPTH (LQ_DEPTH),
        .CNT_W    (CNT_W)
    ) u_late_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (lq_push),
        .entry_i (lq_in),
        .pop_i   (lq_pop),
        .head_o  (lq_head),
        .count_o (lq_count)
    );

    always_comb begin
        case (mem_sel)
            WB_SEL_ALU:  mem_result = mem_alu;
            WB_SEL_LOAD: mem_result = align_load(mem_ldata, mem_ltype, mem_boff);
            WB_SEL_LINK: mem_result = mem_link;
            default:     mem_result = mem_alu;
        endcase
    end

    always_comb begin
        wgpr_d = 1'b0;
        rd_d   = rd_q;
        wd_d   = wd_q;
        if (mem_fire) begin
            wgpr_d = mem_wen && (mem_rd != '0);
            rd_d   = mem_rd;
            wd_d   = mem_result;
        end else if (lq_pop) begin
            wgpr_d = (lq_head.rd != '0);
            rd_d   = lq_head.rd;
            wd_d   = lq_head.data;
        end
    end

    // Clear on commit first so a same-cycle reservation of that register wins.
    always_comb begin
        pend_d = pend_q;
        if (lq_pop && (lq_head.rd != '0)) begin
            pend_d[lq_head.rd] = 1'b0;
        end
        if (late_issue && (late_issue_rd != '0)) begin
            pend_d[late_issue_rd] = 1'b1;
        end
        err_d = err_q
              | (late_issue && (late_issue_rd != '0) && pend_q[late_issue_rd])
              | (lq_push && (late_rd != '0) && !pend_q[late_rd])
              | (mem_fire && mem_wen && (mem_rd != '0) && pend_q[mem_rd]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wgpr_q <= 1'b0;
            rd_q   <= '0;
            wd_q   <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wgpr_q <= wgpr_d;
            rd_q   <= rd_d;
            wd_q   <= wd_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign wGPR       = wgpr_q;
    assign rd         = rd_q;
    assign wd         = wd_q;
    assign fwd_data   = wd_q;
    assign fwd_rs_hit = wgpr_q && (rd_q == rs_q) && (rd_q != '0);
    assign fwd_rt_hit = wgpr_q && (rd_q == rt_q) && (rd_q != '0);
    assign pend_mask  = pend_q;
    assign sb_err     = err_q;

endmodule

// File: tb/tb_gpr_writeback_unit.sv
// Randomised and directed bench for gpr_writeback_unit against a queue-based reference model.
module tb_gpr_writeback_unit;
    import mips_pkg::*;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int LQ_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_valid, mem_ready, mem_wen;
    logic [ADDR_W-1:0] mem_rd;
    logic [1:0]        mem_sel;
    logic [DATA_W-1:0] mem_alu, mem_ldata, mem_link;
    logic [2:0]        mem_ltype;
    logic [1:0]        mem_boff;
    logic              late_issue, late_valid, late_ready;
    logic [ADDR_W-1:0] late_issue_rd, late_rd;
    logic [DATA_W-1:0] late_data;
    logic              wGPR;
    logic [ADDR_W-1:0] rd, rs_q, rt_q;
    logic [DATA_W-1:0] wd, fwd_data;
    logic              fwd_rs_hit, fwd_rt_hit, sb_err;
    logic [31:0]       pend_mask;

    gpr_writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_rd(mem_rd),
        .mem_sel(mem_sel), .mem_alu(mem_alu), .mem_ldata(mem_ldata), .mem_ltype(mem_ltype),
        .mem_boff(mem_boff), .mem_link(mem_link),
        .late_issue(late_issue), .late_issue_rd(late_issue_rd),
        .late_valid(late_valid), .late_ready(late_ready), .late_rd(late_rd), .late_data(late_data),
        .wGPR(wGPR), .rd(rd), .wd(wd), .rs_q(rs_q), .rt_q(rt_q),
        .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit), .fwd_data(fwd_data),
        .pend_mask(pend_mask), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rd;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    bit          m_pend[32];
    logic        m_wgpr;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic        m_err;
    int          outst[$];
    ent_t        commits[$];
    int          stalls;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [31:0] alu,
                                               input logic [31:0] ldata, input logic [2:0] lt,
                                               input logic [1:0] boff, input logic [31:0] link);
        logic [31:0] v;
        int          off;
        off = int'(boff);
        if (sel == 2'b10) return link;
        if (sel != 2'b01) return alu;
        case (lt)
            3'b000, 3'b100: begin
                v = (ldata >> (8 * off)) & 32'hFF;
                if (lt == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                v = (ldata >> (16 * (off / 2))) & 32'hFFFF;
                if (lt == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = ldata;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) if (m_pend[i]) m[i] = 1'b1;
        return m;
    endfunction

    task automatic set_idle();
        mem_valid = 0; mem_wen = 0; mem_rd = '0; mem_sel = '0; mem_alu = '0;
        mem_ldata = '0; mem_ltype = '0; mem_boff = '0; mem_link = '0;
        late_issue = 0; late_issue_rd = '0; late_valid = 0; late_rd = '0; late_data = '0;
        rs_q = '0; rt_q = '0;
    endtask

    task automatic model_reset();
        mq.delete(); outst.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_wgpr = 0; m_rd = '0; m_wd = '0; m_err = 0;
    endtask

    // One clock: check combinational outputs before the edge, advance the model, check registers after.
    task automatic step();
        bit   full, fire, push, pop;
        bit   n_pend[32];
        logic n_wgpr, n_err;
        logic [4:0]  n_rd;
        logic [31:0] n_wd;
        ent_t h;
        @(negedge clk);
        full = (mq.size() == LQ_DEPTH);
        chk("mem_ready", mem_ready, !full);
        chk("late_ready", late_ready, !full);
        chk("fwd_rs_hit", fwd_rs_hit, m_wgpr && m_rd == rs_q && m_rd != 0);
        chk("fwd_rt_hit", fwd_rt_hit, m_wgpr && m_rd == rt_q && m_rd != 0);
        chk("fwd_data", fwd_data, m_wd);
        if (mem_valid && full) stalls++;
        fire = mem_valid && !full;
        push = late_valid && !full;
        pop  = !fire && mq.size() > 0;
        n_pend = m_pend; n_err = m_err; n_wgpr = 0; n_rd = m_rd; n_wd = m_wd;
        if (late_issue && late_issue_rd != 0 && m_pend[late_issue_rd]) n_err = 1;
        if (push && late_rd != 0 && !m_pend[late_rd]) n_err = 1;
        if (fire && mem_wen && mem_rd != 0 && m_pend[mem_rd]) n_err = 1;
        if (fire) begin
            n_wgpr = mem_wen && mem_rd != 0;
            n_rd   = mem_rd;
            n_wd   = ref_result(mem_sel, mem_alu, mem_ldata, mem_ltype, mem_boff, mem_link);
        end else if (pop) begin
            h = mq.pop_front();
            n_wgpr = (h.rd != 0);
            n_rd   = 5'(h.rd);
            n_wd   = h.data;
            if (h.rd != 0) n_pend[h.rd] = 0;
        end
        if (late_issue && late_issue_rd != 0) n_pend[late_issue_rd] = 1;
        if (push) mq.push_back('{int'(late_rd), late_data});
        @(posedge clk);
        #1;
        m_pend = n_pend; m_err = n_err; m_wgpr = n_wgpr; m_rd = n_rd; m_wd = n_wd;
        if (m_wgpr) commits.push_back('{int'(m_rd), m_wd});
        chk("wGPR", wGPR, m_wgpr);
        chk("rd", rd, m_rd);
        chk("wd", wd, m_wd);
        chk("pend_mask", pend_mask, exp_mask());
        chk("sb_err", sb_err, m_err);
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("rst_wGPR", wGPR, 1'b0);
        chk("rst_rd", rd, 5'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_sb_err", sb_err, 1'b0);
        chk("rst_mem_ready", mem_ready, 1'b1);
        chk("rst_late_ready", late_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_hold_wGPR", wGPR, 1'b0);
        rst_n = 1;
    endtask

    task automatic rand_cycles(input int n);
        int idx;
        bit accepted;
        for (int c = 0; c < n; c++) begin
            mem_valid = 1'($urandom_range(0, 1));
            mem_wen   = 1'($urandom_range(0, 3) != 0);
            mem_rd    = 5'($urandom_range(0, 31));
            if (m_pend[mem_rd]) mem_rd = '0;
            mem_sel   = 2'($urandom_range(0, 3));
            mem_alu   = $urandom; mem_ldata = $urandom; mem_link = $urandom;
            mem_ltype = 3'($urandom_range(0, 7));
            mem_boff  = 2'($urandom_range(0, 3));
            rs_q = 5'($urandom_range(0, 31));
            rt_q = 5'($urandom_range(0, 31));
            late_valid = 0; idx = -1;
            if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = int'($urandom_range(0, outst.size() - 1));
                late_valid = 1;
                late_rd    = 5'(outst[idx]);
                late_data  = $urandom;
            end
            accepted = late_valid && (mq.size() != LQ_DEPTH);
            late_issue    = 0;
            late_issue_rd = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 2) == 0 && !m_pend[late_issue_rd]) late_issue = 1;
            step();
            if (accepted) outst.delete(idx);
            if (late_issue) outst.push_back(int'(late_issue_rd));
        end
    endtask

    logic [2:0]  ld_lt   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_boff [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp  [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

    initial begin
        rst_n = 1;
        set_idle();
        model_reset();
        stalls = 0;
        do_reset();
        step();

        // Load alignment
        for (int i = 0; i < 5; i++) begin
            set_idle();
            mem_valid = 1; mem_wen = 1; mem_rd = 5'd4; mem_sel = WB_SEL_LOAD;
            mem_ldata = 32'h80FF_7F01; mem_ltype = ld_lt[i]; mem_boff = ld_boff[i];
            step();
            chk("load_wGPR", wGPR, 1'b1);
            chk("load_rd", rd, 5'd4);
            chk("load_wd", wd, ld_exp[i]);
        end

        // Write to r0 is suppressed
        set_idle();
        mem_valid = 1; mem_wen = 1; mem_rd = '0; mem_sel = WB_SEL_ALU; mem_alu = 32'h1234;
        step();
        chk("r0_wGPR", wGPR, 1'b0);
        chk("r0_pend", pend_mask, 32'd0);
        chk("r0_err", sb_err, 1'b0);

        // Forwarding
        set_idle();
        mem_valid = 1; mem_wen = 1; mem_rd = 5'd9; mem_alu = 32'hCAFE;
        step();
        set_idle();
        rs_q = 5'd9; rt_q = 5'd0;
        #1;
        chk("fwd9_rs", fwd_rs_hit, 1'b1);
        chk("fwd9_rt", fwd_rt_hit, 1'b0);
        chk("fwd9_data", fwd_data, 32'hCAFE);
        mem_valid = 1; mem_wen = 1; mem_rd = '0; mem_alu = 32'h5555;
        step();
        set_idle();
        #1;
        chk("fwd0_rs", fwd_rs_hit, 1'b0);
        chk("fwd0_rt", fwd_rt_hit, 1'b0);

        // Queue full stalls the pipeline for one drain cycle
        set_idle();
        late_issue = 1; late_issue_rd = 5'd7; step();
        late_issue_rd = 5'd8; step();
        late_issue = 0;
        mem_valid = 1; mem_wen = 0; mem_rd = 5'd1;
        late_valid = 1; late_rd = 5'd7; late_data = 32'h11; step();
        late_rd = 5'd8; late_data = 32'h22; step();
        late_valid = 0;
        stalls = 0;
        commits.delete();
        step();
        chk("full_r7_rd", rd, 5'd7);
        chk("full_r7_wd", wd, 32'h11);
        chk("full_r7_pend", pend_mask[8:7], 2'b10);
        step();
        mem_valid = 0;
        step();
        chk("full_r8_rd", rd, 5'd8);
        chk("full_r8_wd", wd, 32'h22);
        chk("full_r8_pend", pend_mask[8:7], 2'b00);
        chk("full_stalls", 64'(stalls), 64'd1);
        chk("full_order_n", 64'(commits.size()), 64'd2);
        if (commits.size() == 2) begin
            chk("full_order_0", 64'(commits[0].rd), 64'd7);
            chk("full_order_1", 64'(commits[1].rd), 64'd8);
        end

        // Random traffic
        set_idle();
        rand_cycles(1500);
        chk("rand_no_err", sb_err, 1'b0);
        set_idle();
        do_reset();

        // Reset with two queued entries
        late_issue = 1; late_issue_rd = 5'd3; step();
        late_issue_rd = 5'd7; step();
        late_issue = 0;
        mem_valid = 1; mem_wen = 0;
        late_valid = 1; late_rd = 5'd3; late_data = 32'hA3; step();
        late_rd = 5'd7; late_data = 32'hA7; step();
        chk("pre_rst_pend", pend_mask, 32'h88);
        chk("pre_rst_full", mem_ready, 1'b0);
        set_idle();
        do_reset();
        commits.delete();
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_no_write", 64'(commits.size()), 64'd0);

        // Double issue raises a sticky error
        set_idle();
        late_issue = 1; late_issue_rd = 5'd3; step();
        outst.push_back(3);
        step();
        late_issue = 0;
        chk("dbl_issue_err", sb_err, 1'b1);
        rand_cycles(60);
        chk("err_sticky", sb_err, 1'b1);
        set_idle();
        do_reset();
        chk("err_cleared", sb_err, 1'b0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
